// File: rtl/resil_pkg.sv
// resil_pkg: shared types and sizing helper for the error-resilient stage controller.
package resil_pkg;

    typedef enum logic [2:0] {IDLE, LAUNCH, EVAL, RECOVER, RESAMPLE} state_e;
    typedef enum logic [1:0] {NONE, E0, E1} err_kind_e;

    // Wait counter must hold DP_LAT-1 as well as either recovery penalty.
    function automatic int pen_cnt_w(input int dp_lat, input int p0, input int p1);
        int m;
        m = (dp_lat > p0) ? dp_lat : p0;
        m = (m > p1) ? m : p1;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/resil_fifo.sv
// resil_fifo: DEPTH-entry synchronous FIFO, registered head, no fall-through,
// occupancy output, async active-low reset.
module resil_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     r_valid,
    output logic [WIDTH-1:0]         r_data,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             do_push, do_pop;

    assign do_pop    = pop & (occ_q != '0);
    assign do_push   = push & ((occ_q != OW'(DEPTH)) | do_pop);
    assign r_valid   = occ_q != '0;
    assign r_data    = mem[rd_q];
    assign occupancy = occ_q;

    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        occ_d = occ_q + OW'(do_push) - OW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= push_data;
    end

endmodule

// File: rtl/resil_stage_ctrl.sv
// resil_stage_ctrl: synchronous error-resilient stage controller with output FIFO.
// Optional saturating error counters enabled by defining RESIL_ERR_CNT_EN.
module resil_stage_ctrl
    import resil_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int DP_LAT       = 2,
    parameter int ERR0_PENALTY = 1,
    parameter int ERR1_PENALTY = 4,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   l_valid,
    output logic                   l_ready,
    input  logic [WIDTH-1:0]       l_data,
    output logic [WIDTH-1:0]       dp_in,
    output logic                   d_launch,
    output logic                   d_sample,
    input  logic [WIDTH-1:0]       dp_data,
    input  logic                   err0,
    input  logic                   err1,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [WIDTH-1:0]       r_data,
`ifdef RESIL_ERR_CNT_EN
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       err0_cnt,
    output logic [CNT_W-1:0]       err1_cnt,
`endif
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PW = pen_cnt_w(DP_LAT, ERR0_PENALTY, ERR1_PENALTY);
    localparam int OW = $clog2(DEPTH) + 1;

    state_e           state_q, state_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dp_in_q, dp_in_d;
    logic             launch_q, launch_d, sample_q, sample_d;
    logic             first_sample, push;
    err_kind_e        ek;

    assign ek           = err1 ? E1 : (err0 ? E0 : NONE);
    assign first_sample = (state_q == EVAL) && (cnt_q == '0);
    assign push         = (first_sample && ek == NONE) || (state_q == RESAMPLE);
    assign l_ready      = rst && (state_q == IDLE) && (occupancy < OW'(DEPTH));
    assign dp_in        = dp_in_q;
    assign d_launch     = launch_q;
    assign d_sample     = sample_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_in_d = dp_in_q;
        unique case (state_q)
            IDLE: begin
                if (l_valid && l_ready) begin
                    dp_in_d = l_data;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = EVAL;
                cnt_d   = PW'(DP_LAT - 1);
            end
            EVAL: begin
                if (cnt_q != '0) cnt_d = cnt_q - PW'(1);
                else if (ek == NONE) state_d = IDLE;
                else begin
                    state_d = RECOVER;
                    cnt_d   = (ek == E1) ? PW'(ERR1_PENALTY) : PW'(ERR0_PENALTY);
                end
            end
            RECOVER: begin
                if (cnt_q == PW'(1)) state_d = RESAMPLE;
                else cnt_d = cnt_q - PW'(1);
            end
            RESAMPLE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Pulses are registered, so decode them from the upcoming state.
        launch_d = state_d == LAUNCH;
        sample_d = (state_d == EVAL && cnt_d == '0) || state_d == RESAMPLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dp_in_q  <= '0;
            launch_q <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dp_in_q  <= dp_in_d;
            launch_q <= launch_d;
            sample_q <= sample_d;
        end
    end

`ifdef RESIL_ERR_CNT_EN
    logic [CNT_W-1:0] err0_cnt_q, err0_cnt_d, err1_cnt_q, err1_cnt_d;

    always_comb begin
        err0_cnt_d = cnt_clr ? '0 : (first_sample && ek == E0 && ~&err0_cnt_q) ? err0_cnt_q + CNT_W'(1) : err0_cnt_q;
        err1_cnt_d = cnt_clr ? '0 : (first_sample && ek == E1 && ~&err1_cnt_q) ? err1_cnt_q + CNT_W'(1) : err1_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err0_cnt_q <= '0;
            err1_cnt_q <= '0;
        end else begin
            err0_cnt_q <= err0_cnt_d;
            err1_cnt_q <= err1_cnt_d;
        end
    end

    assign err0_cnt = err0_cnt_q;
    assign err1_cnt = err1_cnt_q;
`endif

    resil_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (dp_data),
        .pop       (r_ready),
        .r_valid   (r_valid),
        .r_data    (r_data),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_resil_stage_ctrl.sv
// tb_resil_stage_ctrl: directed self-checking bench for resil_stage_ctrl
// (DP_LAT=2, ERR0_PENALTY=1, ERR1_PENALTY=4, DEPTH=4).
module tb_resil_stage_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              l_valid = 1'b0, l_ready;
    logic [WIDTH-1:0]  l_data = '0, dp_in, dp_data = '0, r_data;
    logic              d_launch, d_sample, err0 = 1'b0, err1 = 1'b0;
    logic              r_valid, r_ready = 1'b0;
    logic [2:0]        occupancy;
`ifdef RESIL_ERR_CNT_EN
    logic              cnt_clr = 1'b0;
    logic [15:0]       err0_cnt, err1_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    resil_stage_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DP_LAT(2), .ERR0_PENALTY(1), .ERR1_PENALTY(4), .CNT_W(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .l_valid   (l_valid),
        .l_ready   (l_ready),
        .l_data    (l_data),
        .dp_in     (dp_in),
        .d_launch  (d_launch),
        .d_sample  (d_sample),
        .dp_data   (dp_data),
        .err0      (err0),
        .err1      (err1),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
`ifdef RESIL_ERR_CNT_EN
        .cnt_clr   (cnt_clr),
        .err0_cnt  (err0_cnt),
        .err1_cnt  (err1_cnt),
`endif
        .occupancy (occupancy)
    );

    // Cycle k is the k-th falling edge after the token is offered (cycle 0 = accept cycle).
    // Outputs are recorded there, then that cycle's inputs are driven for the next rising edge.
    task automatic run_token(input logic [31:0] din, input logic [15:0] e0m, input logic [15:0] e1m,
                             input logic [15:0] rrm, input logic [31:0] dpa, input logic [31:0] dpb,
                             input int sw, input int n,
                             output logic [15:0] lv, output logic [15:0] sv, output logic [15:0] rv,
                             output logic [15:0] lr, output logic [31:0] dpin1);
        lv = '0; sv = '0; rv = '0; lr = '0; dpin1 = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            lv[k] = d_launch; sv[k] = d_sample; rv[k] = r_valid; lr[k] = l_ready;
            if (k == 1) dpin1 = dp_in;
            l_valid = (k == 0);
            l_data  = din;
            err0    = e0m[k];
            err1    = e1m[k];
            r_ready = rrm[k];
            dp_data = (k >= sw) ? dpb : dpa;
        end
        l_valid = 1'b0; err0 = 1'b0; err1 = 1'b0; r_ready = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk); r_ready = 1'b1;
        @(negedge clk); r_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks += 6;
        if (l_ready !== 1'b0)   begin errors++; $display("FAIL rst_l_ready: got %b expected 0", l_ready); end
        if (d_launch !== 1'b0)  begin errors++; $display("FAIL rst_d_launch: got %b expected 0", d_launch); end
        if (d_sample !== 1'b0)  begin errors++; $display("FAIL rst_d_sample: got %b expected 0", d_sample); end
        if (r_valid !== 1'b0)   begin errors++; $display("FAIL rst_r_valid: got %b expected 0", r_valid); end
        if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy: got %0d expected 0", occupancy); end
        if (dp_in !== 32'h0)    begin errors++; $display("FAIL rst_dp_in: got %h expected 0", dp_in); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (l_ready !== 1'b1) begin errors++; $display("FAIL idle_l_ready: got %b expected 1", l_ready); end
    endtask

    task automatic test_no_error();
        logic [15:0] lv, sv, rv, lr;
        logic [31:0] d1;
        run_token(32'hA5A5A5A5, 16'h0, 16'h0, 16'h0, 32'h12345678, 32'h12345678, 0, 16, lv, sv, rv, lr, d1);
        checks += 7;
        if (lv !== 16'h0002)      begin errors++; $display("FAIL ne_launch: got %h expected 0002", lv); end
        if (sv !== 16'h0008)      begin errors++; $display("FAIL ne_sample: got %h expected 0008", sv); end
        if (rv !== 16'hFFF0)      begin errors++; $display("FAIL ne_r_valid: got %h expected fff0", rv); end
        if (lr !== 16'hFFF1)      begin errors++; $display("FAIL ne_l_ready: got %h expected fff1", lr); end
        if (d1 !== 32'hA5A5A5A5)  begin errors++; $display("FAIL ne_dp_in: got %h expected a5a5a5a5", d1); end
        if (r_data !== 32'h12345678) begin errors++; $display("FAIL ne_r_data: got %h expected 12345678", r_data); end
        if (occupancy !== 3'd1)   begin errors++; $display("FAIL ne_occ: got %0d expected 1", occupancy); end
        pop_one();
        checks++;
        if (occupancy !== 3'd0) begin errors++; $display("FAIL ne_pop_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_err0();
        logic [15:0] lv, sv, rv, lr;
        logic [31:0] d1;
        run_token(32'h1, 16'h0008, 16'h0, 16'h0, 32'h12345678, 32'h0000BEEF, 4, 16, lv, sv, rv, lr, d1);
        checks += 4;
        if (lv !== 16'h0002) begin errors++; $display("FAIL e0_launch: got %h expected 0002", lv); end
        if (sv !== 16'h0028) begin errors++; $display("FAIL e0_sample: got %h expected 0028", sv); end
        if (rv !== 16'hFFC0) begin errors++; $display("FAIL e0_r_valid: got %h expected ffc0", rv); end
        if (r_data !== 32'h0000BEEF) begin errors++; $display("FAIL e0_r_data: got %h expected 0000beef", r_data); end
`ifdef RESIL_ERR_CNT_EN
        checks += 2;
        if (err0_cnt !== 16'd1) begin errors++; $display("FAIL e0_cnt0: got %0d expected 1", err0_cnt); end
        if (err1_cnt !== 16'd0) begin errors++; $display("FAIL e0_cnt1: got %0d expected 0", err1_cnt); end
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
`endif
        pop_one();
    endtask

    task automatic test_err1();
        logic [15:0] lv, sv, rv, lr;
        logic [31:0] d1;
        run_token(32'h2, 16'h0008, 16'h0008, 16'h0, 32'h11111111, 32'h22222222, 5, 16, lv, sv, rv, lr, d1);
        checks += 4;
        if (sv !== 16'h0108) begin errors++; $display("FAIL e1_sample: got %h expected 0108", sv); end
        if (rv !== 16'hFE00) begin errors++; $display("FAIL e1_r_valid: got %h expected fe00", rv); end
        if (lr !== 16'hFE01) begin errors++; $display("FAIL e1_l_ready: got %h expected fe01", lr); end
        if (r_data !== 32'h22222222) begin errors++; $display("FAIL e1_r_data: got %h expected 22222222", r_data); end
`ifdef RESIL_ERR_CNT_EN
        checks += 2;
        if (err1_cnt !== 16'd1) begin errors++; $display("FAIL e1_cnt1: got %0d expected 1", err1_cnt); end
        if (err0_cnt !== 16'd0) begin errors++; $display("FAIL e1_cnt0: got %0d expected 0", err0_cnt); end
`endif
        pop_one();
    endtask

    task automatic test_err_outside_sample();
        logic [15:0] lv, sv, rv, lr;
        logic [31:0] d1;
        run_token(32'h3, 16'h0, 16'h0014, 16'h0, 32'h33333333, 32'h33333333, 0, 16, lv, sv, rv, lr, d1);
        checks += 3;
        if (sv !== 16'h0008) begin errors++; $display("FAIL ns_sample: got %h expected 0008", sv); end
        if (rv !== 16'hFFF0) begin errors++; $display("FAIL ns_r_valid: got %h expected fff0", rv); end
        if (r_data !== 32'h33333333) begin errors++; $display("FAIL ns_r_data: got %h expected 33333333", r_data); end
        pop_one();
    endtask

    task automatic test_full_and_pushpop();
        logic [15:0] lv, sv, rv, lr;
        logic [31:0] d1;
        logic [31:0] exp_q [3];
        for (int i = 0; i < 4; i++) begin
            run_token(32'h10 + i, 16'h0, 16'h0, 16'h0, 32'h100 + i, 32'h100 + i, 0, 6, lv, sv, rv, lr, d1);
            checks++;
            if (lr[0] !== 1'b1) begin errors++; $display("FAIL fill_accept%0d: got %b expected 1", i, lr[0]); end
        end
        @(negedge clk);
        checks += 3;
        if (occupancy !== 3'd4)   begin errors++; $display("FAIL full_occ: got %0d expected 4", occupancy); end
        if (l_ready !== 1'b0)     begin errors++; $display("FAIL full_l_ready: got %b expected 0", l_ready); end
        if (r_data !== 32'h100)   begin errors++; $display("FAIL full_head: got %h expected 00000100", r_data); end
        pop_one();
        checks += 3;
        if (l_ready !== 1'b1)     begin errors++; $display("FAIL unfull_l_ready: got %b expected 1", l_ready); end
        if (occupancy !== 3'd3)   begin errors++; $display("FAIL unfull_occ: got %0d expected 3", occupancy); end
        if (r_data !== 32'h101)   begin errors++; $display("FAIL unfull_head: got %h expected 00000101", r_data); end
        // Pop lands on the same edge as the FIFO write of the new token.
        run_token(32'h20, 16'h0, 16'h0, 16'h0008, 32'h200, 32'h200, 0, 6, lv, sv, rv, lr, d1);
        checks++;
        if (occupancy !== 3'd3) begin errors++; $display("FAIL pushpop_occ: got %0d expected 3", occupancy); end
        exp_q[0] = 32'h102; exp_q[1] = 32'h103; exp_q[2] = 32'h200;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (r_data !== exp_q[i]) begin errors++; $display("FAIL drain%0d: got %h expected %h", i, r_data, exp_q[i]); end
            pop_one();
        end
        checks++;
        if (occupancy !== 3'd0) begin errors++; $display("FAIL drain_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_reset_in_recover();
        logic [15:0] lv, sv, rv, lr;
        logic [31:0] d1;
        int pulses;
        for (int i = 0; i < 2; i++)
            run_token(32'h30 + i, 16'h0, 16'h0, 16'h0, 32'h300 + i, 32'h300 + i, 0, 6, lv, sv, rv, lr, d1);
        run_token(32'h40, 16'h0, 16'h0008, 16'h0, 32'h400, 32'h401, 0, 6, lv, sv, rv, lr, d1);
        checks++;
        if (occupancy !== 3'd2) begin errors++; $display("FAIL prerst_occ: got %0d expected 2", occupancy); end
        #2 rst = 1'b0;
        #1;
        checks += 5;
        if (l_ready !== 1'b0)   begin errors++; $display("FAIL mrst_l_ready: got %b expected 0", l_ready); end
        if (d_sample !== 1'b0)  begin errors++; $display("FAIL mrst_d_sample: got %b expected 0", d_sample); end
        if (r_valid !== 1'b0)   begin errors++; $display("FAIL mrst_r_valid: got %b expected 0", r_valid); end
        if (occupancy !== 3'd0) begin errors++; $display("FAIL mrst_occ: got %0d expected 0", occupancy); end
        if (dp_in !== 32'h0)    begin errors++; $display("FAIL mrst_dp_in: got %h expected 0", dp_in); end
        @(negedge clk); rst = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            pulses += int'(d_sample) + int'(d_launch) + int'(r_valid);
        end
        checks += 3;
        if (pulses != 0)        begin errors++; $display("FAIL postrst_activity: got %0d expected 0", pulses); end
        if (occupancy !== 3'd0) begin errors++; $display("FAIL postrst_occ: got %0d expected 0", occupancy); end
        if (l_ready !== 1'b1)   begin errors++; $display("FAIL postrst_l_ready: got %b expected 1", l_ready); end
    endtask

    initial begin
        test_reset();
        test_no_error();
        test_err0();
        test_err1();
        test_err_outside_sample();
        test_full_and_pushpop();
        test_reset_in_recover();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
